pq_op_scheduler: RTL
====================

PQ_OP_SCHEDULER -- requirements
Module: pq_op_scheduler

Interface
REQ-001 Parameter KEY_WIDTH, default 16: key field width, matching pq_pkg.
REQ-002 Parameter VAL_WIDTH, default 16: value field width, matching pq_pkg.
REQ-003 Parameter CAPACITY, default 15: PQ entry capacity.
REQ-004 Parameter OP_SPACE, default 4, legal range >=1: minimum idle cycles between PQ strobes.
REQ-005 Interface clocking and reset SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-006 clk  in  1  clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 enq_valid  in  1  producer has a key/value to insert.
REQ-009 enq_kv  in  KEY_WIDTH+VAL_WIDTH  producer key/value pair, with {key,val} packing.
REQ-010 enq_ready  out  1  producer request accepted this cycle.
REQ-011 deq_valid  in  1  consumer requests removal of the top entry.
REQ-012 deq_ready  out  1  consumer request accepted this cycle.
REQ-013 rsp_valid  out  1  dequeued key/value available.
REQ-014 rsp_kv  out  KEY_WIDTH+VAL_WIDTH  dequeued key/value pair.
REQ-015 rsp_ready  in  1  consumer takes rsp_kv.
REQ-016 pq_enq  out  1  PQ enqueue strobe.
REQ-017 pq_deq  out  1  PQ dequeue strobe.
REQ-018 pq_kvi  out  KEY_WIDTH+VAL_WIDTH  PQ input pair.
REQ-019 pq_kvo  in  KEY_WIDTH+VAL_WIDTH  PQ current top pair.
REQ-020 count  out  $clog2(CAPACITY+1)  entries held; empty = (count==0) and full = (count==CAPACITY) are outputs.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE and WAIT.
REQ-022 enq_ready and deq_ready SHALL be asserted only in IDLE.
REQ-023 A handshake SHALL occur when valid and ready are both high in the same cycle.
REQ-024 Replace condition: in IDLE with both valids high, !empty and !rsp_valid, both readys SHALL be high, giving an enq+deq (replace) operation.
REQ-025 Both valids with empty: only enq_ready SHALL be high; the deq stalls.
REQ-026 Both valids with rsp_valid=1: only enq_ready SHALL be high, and only if !full.
REQ-027 enq_valid alone: enq_ready = !full.
REQ-028 deq_valid alone: deq_ready = !empty & !rsp_valid.
REQ-029 On any handshake, the FSM SHALL move IDLE->ISSUE and register the op and enq_kv.
REQ-030 In ISSUE, pq_enq/pq_deq SHALL pulse high for exactly one cycle, with pq_kvi = the registered pair.
REQ-031 The FSM SHALL go ISSUE->WAIT if OP_SPACE>1, else ISSUE->IDLE.
REQ-032 WAIT SHALL last OP_SPACE-1 cycles, counted by a down-counter, then go to IDLE.
REQ-033 Consecutive PQ strobes SHALL be separated by at least OP_SPACE low cycles, the IDLE accept cycle included.
REQ-034 In ISSUE with a deq, pq_kvo SHALL be captured into rsp_kv and rsp_valid set on the next edge.
REQ-035 rsp_valid SHALL clear on rsp_valid & rsp_ready.
REQ-036 count SHALL update at the ISSUE edge: +1 for enq, -1 for deq, unchanged for replace.
REQ-037 count SHALL never wrap: enq at full and deq at empty are never issued.
REQ-038 Outside ISSUE, pq_enq = pq_deq = 0.
REQ-039 pq_kvi SHALL hold its last value when idle.

Reset
REQ-040 rst_n low, at any time including mid-WAIT or ISSUE, SHALL immediately force IDLE, pq_enq=0, pq_deq=0, pq_kvi=0, rsp_valid=0, rsp_kv=0, count=0, wait counter=0, enq_ready=0 and deq_ready=0.
REQ-041 The first handshake SHALL be possible in the first cycle after rst_n rises.
REQ-042 The PQ SHALL be reset from the same reset event; count has no resynchronization with the PQ.

Verification
REQ-043 Single enq: enq <15,15> after reset -> pq_enq pulse 1 cycle after the handshake, pq_kvi={15,15}, count=1, next enq_ready no earlier than 4 cycles after the pulse.
REQ-044 Fill: enqueue 15,11,9,8,35,20,6,12,18,60,5,40,17,85,3 -> count=15, full=1, a 16th enq_valid held for 20 cycles sees enq_ready=0.
REQ-045 Replace: full PQ, top {3,3}, enq <33,33> with deq_valid -> single cycle with pq_enq=pq_deq=1, rsp_kv={3,3}, count stays 15.
REQ-046 Empty deq: count=0, deq_valid held -> deq_ready=0, no pq_deq; simultaneous enq <7,7> -> enq only, count=1, deq accepted in a later IDLE with rsp_kv={7,7}.
REQ-047 Backpressure: rsp_valid=1 with rsp_ready=0 -> deq_ready=0 while pending enq proceeds; rsp_ready=1 -> rsp_valid clears the next cycle.
REQ-048 Reset mid-op: rst_n low during WAIT after an enq -> all outputs zero immediately, count=0, IDLE on release; OP_SPACE=1 build -> strobes every 2 cycles under continuous enq_valid.

Source files
------------

// File: rtl/pq_op_scheduler.sv
// Paces enqueue, dequeue and replace operations onto an external priority queue,
// spacing PQ strobes by OP_SPACE idle cycles and holding one dequeued response.
module pq_op_scheduler #(
    parameter int KEY_WIDTH = 16,
    parameter int VAL_WIDTH = 16,
    parameter int CAPACITY  = 15,
    parameter int OP_SPACE  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 enq_valid_i,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0]       enq_kv_i,
    output logic                                 enq_ready_o,
    input  logic                                 deq_valid_i,
    output logic                                 deq_ready_o,
    output logic                                 rsp_valid_o,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0]       rsp_kv_o,
    input  logic                                 rsp_ready_i,
    output logic                                 pq_enq_o,
    output logic                                 pq_deq_o,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0]       pq_kvi_o,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0]       pq_kvo_i,
    output logic [$clog2(CAPACITY+1)-1:0]        count_o,
    output logic                                 empty_o,
    output logic                                 full_o
);

    localparam int KVW  = KEY_WIDTH + VAL_WIDTH;
    localparam int CNTW = $clog2(CAPACITY + 1);
    localparam int WCW  = $clog2(OP_SPACE + 1);
    localparam logic [WCW-1:0]  WAIT_LOAD = WCW'(OP_SPACE - 1);
    localparam logic [CNTW-1:0] CNT_FULL  = CNTW'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          state_q;
    logic            pq_enq_q;
    logic            pq_deq_q;
    logic [KVW-1:0]  pq_kvi_q;
    logic            rsp_valid_q;
    logic [KVW-1:0]  rsp_kv_q;
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;
    logic [WCW-1:0]  wait_q;

    logic is_idle;
    logic full;
    logic empty;
    logic deq_ok;
    logic enq_ok;
    logic deq_hs_ok;
    logic do_enq;
    logic do_deq;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign is_idle   = (state_q == IDLE);
    assign deq_ok    = !empty && !rsp_valid_q;
    // A replace keeps the occupancy constant, so it is allowed even when full.
    assign enq_ok    = is_idle && enq_valid_i && (!full || (deq_valid_i && deq_ok));
    assign deq_hs_ok = is_idle && deq_valid_i && deq_ok;
    assign do_enq    = enq_ok;
    assign do_deq    = deq_hs_ok;

    // rst_n only gates the outputs here so the readys drop the instant reset asserts.
    assign enq_ready_o = enq_ok && rst_n;
    assign deq_ready_o = deq_hs_ok && rst_n;

    always_comb begin
        count_d = count_q;
        if (pq_enq_q && !pq_deq_q) begin
            count_d = count_q + CNTW'(1);
        end else if (pq_deq_q && !pq_enq_q) begin
            count_d = count_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pq_enq_q    <= 1'b0;
            pq_deq_q    <= 1'b0;
            pq_kvi_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_kv_q    <= '0;
            count_q     <= '0;
            wait_q      <= '0;
        end else begin
            if (rsp_valid_q && rsp_ready_i) begin
                rsp_valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (do_enq || do_deq) begin
                        state_q  <= ISSUE;
                        pq_enq_q <= do_enq;
                        pq_deq_q <= do_deq;
                        if (do_enq) begin
                            pq_kvi_q <= enq_kv_i;
                        end
                    end
                end
                ISSUE: begin
                    pq_enq_q <= 1'b0;
                    pq_deq_q <= 1'b0;
                    count_q  <= count_d;
                    // pq_kvo_i still shows the pre-operation top during the strobe cycle.
                    if (pq_deq_q) begin
                        rsp_kv_q    <= pq_kvo_i;
                        rsp_valid_q <= 1'b1;
                    end
                    if (OP_SPACE > 1) begin
                        state_q <= WAIT;
                        wait_q  <= WAIT_LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (wait_q <= WCW'(1)) begin
                        state_q <= IDLE;
                        wait_q  <= '0;
                    end else begin
                        wait_q <= wait_q - WCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pq_enq_o    = pq_enq_q;
    assign pq_deq_o    = pq_deq_q;
    assign pq_kvi_o    = pq_kvi_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_kv_o    = rsp_kv_q;
    assign count_o     = count_q;
    assign empty_o     = empty;
    assign full_o      = full;

endmodule
